ysyx_22040750_lsu: RTL and testbench
====================================

YSYX_22040750_LSU -- requirements
Module: ysyx_22040750_lsu

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- I_clk  in  1  clock.
- I_rst  in  1  synchronous, active-high reset.
- I_valid  in  1  memory-stage op valid.
- I_ren  in  1  load.
- I_wen  in  1  store.
- I_funct3  in  3  size[1:0] (0=B, 1=H, 2=W, 3=D); bit2 = zero-extend.
- I_addr  in  32  byte address.
- I_wdata  in  64  store data, LSB-aligned.
- O_rdata  out  64  extended load result.
- O_done  out  1  op complete.
- O_stall  out  1  hold pipeline.
- O_misalign  out  1  misaligned-access flag.
- O_dc_addr  out  32  cache address.
- O_dc_wdata  out  64  lane-aligned store data.
- O_dc_wmask  out  8  byte strobes, high = write.
- O_dc_rd_req  out  1  read request.
- O_dc_wr_req  out  1  write request.
- I_dc_ready  in  1  cache accepts request.
- I_dc_rdata  in  64  cache doubleword.
- I_dc_rvalid  in  1  read data valid.
- I_dc_bvalid  in  1  write complete.

Function
REQ-002 SHALL implement FSM states IDLE, WAIT_RD, WAIT_WR, RESP.
REQ-003 In IDLE with I_valid&&(I_ren||I_wen)&&I_dc_ready: SHALL assert exactly one of O_dc_rd_req/O_dc_wr_req for that single cycle, then go to WAIT_RD or WAIT_WR.
REQ-004 Request SHALL be held off while I_dc_ready=0, and O_dc_*_req SHALL be 0 in every state other than the IDLE issue cycle.
REQ-005 If I_ren and I_wen are both 1, the op SHALL be treated as a load.
REQ-006 O_dc_addr SHALL equal I_addr unmodified; the cache selects the doubleword by addr[4:3].
REQ-007 Store lane alignment:
- O_dc_wdata SHALL be I_wdata shifted left by addr[2:0]*8.
- O_dc_wmask SHALL be (B:0x01, H:0x03, W:0x0F, D:0xFF) shifted left by addr[2:0], truncated to 8 bits.
REQ-008 WAIT_RD on I_dc_rvalid:
- SHALL register (I_dc_rdata >> addr[2:0]*8).
- SHALL sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) it from the access size into O_rdata.
- SHALL go to RESP.
REQ-009 WAIT_WR on I_dc_bvalid SHALL go to RESP; O_rdata SHALL be unchanged.
REQ-010 Addr[2:0] and funct3 SHALL be latched at issue and used for extraction; pipeline inputs may change after issue.
REQ-011 O_done SHALL be 1 only in RESP, for exactly one cycle; RESP SHALL go to IDLE unconditionally.
REQ-012 O_stall SHALL be I_valid&&(I_ren||I_wen)&&(state!=RESP); the op SHALL NOT be reissued in RESP.
REQ-013 I_dc_rvalid/I_dc_bvalid SHALL be ignored outside WAIT_RD/WAIT_WR respectively.
REQ-014 Minimum load latency SHALL be issue + 1 (cache hit) + 1 (RESP) = O_done 2 cycles after issue.

Reset
REQ-015 On I_rst the FSM SHALL go to IDLE and O_rdata and latched addr/funct3 SHALL clear to 0.
REQ-016 During reset, O_done, O_stall, O_misalign, O_dc_rd_req and O_dc_wr_req SHALL be 0.
REQ-017 Reset mid-operation SHALL abandon the outstanding access; a late cache response SHALL be ignored per REQ-013.

Configuration
REQ-018 Macro YSYX_22040750_LSU_MISALIGN_CHK_EN SHALL control misaligned-access handling:
- Defined: an op with addr not a multiple of its size SHALL issue no cache request, go IDLE->RESP, and assert O_misalign with O_done for one cycle; O_rdata SHALL be cleared to 0.
- Undefined: no check is made, O_misalign SHALL be tied 0, and accesses crossing the doubleword are truncated per REQ-007.

Verification
REQ-019 Bench SHALL cover:
- LB addr 0x80000007, cache rdata 0x8000_0000_0000_0000 -> O_rdata 0xFFFF_FFFF_FFFF_FF80; O_done 2 cycles after issue.
- LHU addr 0x80000002, rdata 0x0000_0000_8001_0000 -> O_rdata 0x0000_0000_0000_8001.
- SW addr 0x80000004, I_wdata 0x1122_3344 -> O_dc_wdata 0x1122_3344_0000_0000, wmask 0xF0, single-cycle wr_req, O_done one cycle after bvalid.
- I_dc_ready low for 5 cycles with load pending -> no req for 5 cycles, O_stall held, single req on cycle 6.
- I_rst asserted in WAIT_RD, then rvalid arrives -> state IDLE, O_done stays 0, O_rdata 0.
- With macro defined, LW addr 0x80000002 -> no req, O_misalign=O_done=1 for one cycle; without macro, the same op -> read req issued, O_misalign 0.

Source files
------------

// File: rtl/ysyx_22040750_lsu.sv
// Load/store unit between the memory pipeline stage and the data cache.
// Latency: a load completes (O_done) two cycles after issue on a cache hit; a store completes one cycle after the write response.
// Backpressure: holds the request while I_dc_ready is low and asserts O_stall until the RESP cycle.
// Optional feature: define YSYX_22040750_LSU_MISALIGN_CHK_EN to reject misaligned accesses without touching the cache.
module ysyx_22040750_lsu (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    input  logic        I_ren,
    input  logic        I_wen,
    input  logic [2:0]  I_funct3,
    input  logic [31:0] I_addr,
    input  logic [63:0] I_wdata,
    output logic [63:0] O_rdata,
    output logic        O_done,
    output logic        O_stall,
    output logic        O_misalign,
    output logic [31:0] O_dc_addr,
    output logic [63:0] O_dc_wdata,
    output logic [7:0]  O_dc_wmask,
    output logic        O_dc_rd_req,
    output logic        O_dc_wr_req,
    input  logic        I_dc_ready,
    input  logic [63:0] I_dc_rdata,
    input  logic        I_dc_rvalid,
    input  logic        I_dc_bvalid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Access shape captured at issue; the pipeline may move on afterwards.
    logic [2:0]  off_q;
    logic [2:0]  f3_q;
    logic        mis_q;
    logic [63:0] rdata_q;

    logic        op_vld;
    logic        misal;
    logic        issue;
    logic [63:0] shifted;
    logic [63:0] load_ext;
    logic [7:0]  size_mask;

    assign op_vld = I_valid && (I_ren || I_wen);

`ifdef YSYX_22040750_LSU_MISALIGN_CHK_EN
    // Address must be a multiple of the access size.
    always_comb begin
        misal = 1'b0;
        case (I_funct3[1:0])
            2'd0:    misal = 1'b0;
            2'd1:    misal = I_addr[0];
            2'd2:    misal = |I_addr[1:0];
            default: misal = |I_addr[2:0];
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    // A request goes out only from IDLE, for an aligned op the cache can take now.
    assign issue = (state == IDLE) && op_vld && !misal && I_dc_ready;

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a load wins when both I_ren and I_wen are set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (op_vld && misal) begin
                    state_nxt = RESP;
                end else if (issue) begin
                    state_nxt = I_ren ? WAIT_RD : WAIT_WR;
                end
            end
            WAIT_RD: begin
                if (I_dc_rvalid) begin
                    state_nxt = RESP;
                end
            end
            WAIT_WR: begin
                if (I_dc_bvalid) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs; all forced low while reset is asserted.
    always_comb begin
        O_dc_rd_req = !I_rst && issue && I_ren;
        O_dc_wr_req = !I_rst && issue && !I_ren;
        O_done      = !I_rst && (state == RESP);
        O_stall     = !I_rst && op_vld && (state != RESP);
        O_misalign  = !I_rst && (state == RESP) && mis_q;
    end

    // Store path: move data and strobes into the addressed byte lanes.
    always_comb begin
        size_mask = 8'h01;
        case (I_funct3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign O_dc_addr  = I_addr;
    assign O_dc_wdata = I_wdata << {I_addr[2:0], 3'b000};
    assign O_dc_wmask = size_mask << I_addr[2:0];

    // Load path: bring the addressed bytes to bit 0 and extend from the access size.
    assign shifted = I_dc_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (f3_q[1:0])
            2'd0:    load_ext = {{56{shifted[7]  && !f3_q[2]}}, shifted[7:0]};
            2'd1:    load_ext = {{48{shifted[15] && !f3_q[2]}}, shifted[15:0]};
            2'd2:    load_ext = {{32{shifted[31] && !f3_q[2]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Capture byte offset and funct3 at issue.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            off_q <= 3'd0;
            f3_q  <= 3'd0;
        end else if (issue) begin
            off_q <= I_addr[2:0];
            f3_q  <= I_funct3;
        end
    end

    // Misalign flag lives for the RESP cycle of a rejected op.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mis_q <= 1'b0;
        end else if ((state == IDLE) && op_vld && misal) begin
            mis_q <= 1'b1;
        end else if (state == RESP) begin
            mis_q <= 1'b0;
        end
    end

    // Load result register; stores leave it untouched, rejected ops clear it.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rdata_q <= 64'd0;
        end else if ((state == IDLE) && op_vld && misal) begin
            rdata_q <= 64'd0;
        end else if ((state == WAIT_RD) && I_dc_rvalid) begin
            rdata_q <= load_ext;
        end
    end

    assign O_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_22040750_lsu.sv
module tb_ysyx_22040750_lsu;

    logic        I_clk;
    logic        I_rst;
    logic        I_valid;
    logic        I_ren;
    logic        I_wen;
    logic [2:0]  I_funct3;
    logic [31:0] I_addr;
    logic [63:0] I_wdata;
    logic [63:0] O_rdata;
    logic        O_done;
    logic        O_stall;
    logic        O_misalign;
    logic [31:0] O_dc_addr;
    logic [63:0] O_dc_wdata;
    logic [7:0]  O_dc_wmask;
    logic        O_dc_rd_req;
    logic        O_dc_wr_req;
    logic        I_dc_ready;
    logic [63:0] I_dc_rdata;
    logic        I_dc_rvalid;
    logic        I_dc_bvalid;

    ysyx_22040750_lsu dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_valid     (I_valid),
        .I_ren       (I_ren),
        .I_wen       (I_wen),
        .I_funct3    (I_funct3),
        .I_addr      (I_addr),
        .I_wdata     (I_wdata),
        .O_rdata     (O_rdata),
        .O_done      (O_done),
        .O_stall     (O_stall),
        .O_misalign  (O_misalign),
        .O_dc_addr   (O_dc_addr),
        .O_dc_wdata  (O_dc_wdata),
        .O_dc_wmask  (O_dc_wmask),
        .O_dc_rd_req (O_dc_rd_req),
        .O_dc_wr_req (O_dc_wr_req),
        .I_dc_ready  (I_dc_ready),
        .I_dc_rdata  (I_dc_rdata),
        .I_dc_rvalid (I_dc_rvalid),
        .I_dc_bvalid (I_dc_bvalid)
    );

`ifdef YSYX_22040750_LSU_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load rule: pick bytes at the offset, keep 2^size of them, extend.
    function automatic logic [63:0] model_load(input logic [63:0] line, input logic [2:0] off,
                                               input logic [2:0] f3);
        logic [63:0] v;
        logic [63:0] mask;
        int          nbits;
        nbits = 8 << f3[1:0];
        v     = line >> (8 * off);
        mask  = (nbits == 64) ? ~64'd0 : ((64'd1 << nbits) - 64'd1);
        v     = v & mask;
        if (!f3[2] && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] model_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << (1 << f3[1:0])) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic bit model_misal(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return CHK_EN && ((addr % nbytes) != 0);
    endfunction

    // Transaction-level model: what is outstanding, and the last load result.
    typedef enum int {M_FREE, M_LOAD, M_STORE, M_DONE} mphase_t;
    mphase_t     m_phase = M_FREE;
    logic [63:0] m_rdata = 64'd0;
    logic [2:0]  m_off   = 3'd0;
    logic [2:0]  m_f3    = 3'd0;
    bit          m_mis   = 1'b0;

    always @(posedge I_clk) begin
        if (I_rst) begin
            m_phase = M_FREE;
            m_rdata = 64'd0;
            m_off   = 3'd0;
            m_f3    = 3'd0;
            m_mis   = 1'b0;
        end else begin
            case (m_phase)
                M_FREE: begin
                    if (I_valid && (I_ren || I_wen)) begin
                        if (model_misal(I_funct3, I_addr)) begin
                            m_phase = M_DONE;
                            m_mis   = 1'b1;
                            m_rdata = 64'd0;
                        end else if (I_dc_ready) begin
                            m_off   = I_addr[2:0];
                            m_f3    = I_funct3;
                            m_phase = I_ren ? M_LOAD : M_STORE;
                        end
                    end
                end
                M_LOAD: begin
                    if (I_dc_rvalid) begin
                        m_rdata = model_load(I_dc_rdata, m_off, m_f3);
                        m_phase = M_DONE;
                    end
                end
                M_STORE: begin
                    if (I_dc_bvalid) m_phase = M_DONE;
                end
                default: begin
                    m_phase = M_FREE;
                    m_mis   = 1'b0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    logic e_op;
    logic e_issue;
    always @(negedge I_clk) begin
        if (cmp_en) begin
            e_op    = I_valid && (I_ren || I_wen);
            e_issue = !I_rst && (m_phase == M_FREE) && e_op && I_dc_ready
                      && !model_misal(I_funct3, I_addr);
            chk("cmp_rd_req",   {63'd0, O_dc_rd_req}, {63'd0, e_issue && I_ren});
            chk("cmp_wr_req",   {63'd0, O_dc_wr_req}, {63'd0, e_issue && !I_ren});
            chk("cmp_done",     {63'd0, O_done},      {63'd0, !I_rst && (m_phase == M_DONE)});
            chk("cmp_stall",    {63'd0, O_stall},     {63'd0, !I_rst && e_op && (m_phase != M_DONE)});
            chk("cmp_misalign", {63'd0, O_misalign},  {63'd0, !I_rst && (m_phase == M_DONE) && m_mis});
            chk("cmp_rdata",    O_rdata,              m_rdata);
            chk("cmp_addr",     {32'd0, O_dc_addr},   {32'd0, I_addr});
            if (e_issue && !I_ren) begin
                chk("cmp_wdata", O_dc_wdata, I_wdata << (8 * I_addr[2:0]));
                chk("cmp_wmask", {56'd0, O_dc_wmask}, {56'd0, model_mask(I_funct3, I_addr[2:0])});
            end
        end
    end

    task automatic tick;
        @(posedge I_clk);
        #1;
    endtask

    task automatic sample;
        @(negedge I_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        I_rst = 1'b1; I_valid = 1'b1; I_ren = 1'b1; I_wen = 1'b0;
        I_funct3 = 3'd0; I_addr = 32'h8000_0000; I_wdata = 64'd0;
        I_dc_ready = 1'b1; I_dc_rdata = 64'd0; I_dc_rvalid = 1'b0; I_dc_bvalid = 1'b0;

        // Reset held with a pending load at the inputs.
        tick;
        cmp_en = 1'b1;
        tick;
        sample;
        chk("rst_done",   {63'd0, O_done},      64'd0);
        chk("rst_stall",  {63'd0, O_stall},     64'd0);
        chk("rst_rd_req", {63'd0, O_dc_rd_req}, 64'd0);
        chk("rst_rdata",  O_rdata,              64'd0);
        I_rst = 1'b0; I_valid = 1'b0; I_ren = 1'b0;
        tick;

        // LB 0x80000007, inputs scrambled after issue.
        I_valid = 1'b1; I_ren = 1'b1; I_funct3 = 3'b000; I_addr = 32'h8000_0007;
        sample;
        chk("lb_req", {63'd0, O_dc_rd_req}, 64'd1);
        tick;
        I_addr = 32'h1234_5678; I_funct3 = 3'b011;
        I_dc_rvalid = 1'b1; I_dc_rdata = 64'h8000_0000_0000_0000;
        sample;
        chk("lb_req_once",  {63'd0, O_dc_rd_req}, 64'd0);
        chk("lb_done_early", {63'd0, O_done},     64'd0);
        tick;
        I_dc_rvalid = 1'b0; I_dc_rdata = 64'd0;
        sample;
        chk("lb_done",       {63'd0, O_done},      64'd1);
        chk("lb_rdata",      O_rdata,              64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_resp_stall", {63'd0, O_stall},     64'd0);
        chk("lb_no_reissue", {63'd0, O_dc_rd_req}, 64'd0);
        tick;
        I_valid = 1'b0;
        sample;
        chk("lb_done_once", {63'd0, O_done}, 64'd0);
        tick;

        // LHU 0x80000002 with one miss cycle.
        I_valid = 1'b1; I_ren = 1'b1; I_funct3 = 3'b101; I_addr = 32'h8000_0002;
        sample;
        chk("lhu_req", {63'd0, O_dc_rd_req}, 64'd1);
        tick;
        sample;
        chk("lhu_wait_done", {63'd0, O_done}, 64'd0);
        tick;
        I_dc_rvalid = 1'b1; I_dc_rdata = 64'h0000_0000_8001_0000;
        sample;
        tick;
        I_dc_rvalid = 1'b0;
        sample;
        chk("lhu_done",  {63'd0, O_done}, 64'd1);
        chk("lhu_rdata", O_rdata,         64'h0000_0000_0000_8001);
        tick;
        I_valid = 1'b0;
        tick;

        // SW 0x80000004; a stray rvalid while waiting must be ignored.
        I_valid = 1'b1; I_ren = 1'b0; I_wen = 1'b1; I_funct3 = 3'b010;
        I_addr = 32'h8000_0004; I_wdata = 64'h0000_0000_1122_3344;
        sample;
        chk("sw_wr_req", {63'd0, O_dc_wr_req}, 64'd1);
        chk("sw_rd_req", {63'd0, O_dc_rd_req}, 64'd0);
        chk("sw_wdata",  O_dc_wdata,           64'h1122_3344_0000_0000);
        chk("sw_wmask",  {56'd0, O_dc_wmask},  64'hF0);
        tick;
        I_dc_rvalid = 1'b1; I_dc_rdata = ~64'd0;
        sample;
        chk("sw_wr_once", {63'd0, O_dc_wr_req}, 64'd0);
        tick;
        I_dc_rvalid = 1'b0; I_dc_bvalid = 1'b1;
        sample;
        chk("sw_done_early", {63'd0, O_done}, 64'd0);
        tick;
        I_dc_bvalid = 1'b0;
        sample;
        chk("sw_done",  {63'd0, O_done}, 64'd1);
        chk("sw_rdata", O_rdata,         64'h0000_0000_0000_8001);
        tick;
        I_valid = 1'b0; I_wen = 1'b0;
        tick;

        // LD with the cache busy for 5 cycles.
        I_dc_ready = 1'b0;
        I_valid = 1'b1; I_ren = 1'b1; I_funct3 = 3'b011; I_addr = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            sample;
            chk("rdy_noreq", {63'd0, O_dc_rd_req}, 64'd0);
            chk("rdy_stall", {63'd0, O_stall},     64'd1);
            tick;
        end
        I_dc_ready = 1'b1;
        sample;
        chk("rdy_req", {63'd0, O_dc_rd_req}, 64'd1);
        tick;
        I_dc_rvalid = 1'b1; I_dc_rdata = 64'h0123_4567_89AB_CDEF;
        sample;
        chk("rdy_req_once", {63'd0, O_dc_rd_req}, 64'd0);
        tick;
        I_dc_rvalid = 1'b0;
        sample;
        chk("ld_rdata", O_rdata, 64'h0123_4567_89AB_CDEF);
        tick;
        I_valid = 1'b0;
        tick;

        // Reset while waiting for load data, then a late response.
        I_valid = 1'b1; I_ren = 1'b1; I_funct3 = 3'b010; I_addr = 32'h8000_0000;
        sample;
        tick;
        I_rst = 1'b1;
        sample;
        chk("rstmid_done",  {63'd0, O_done},  64'd0);
        chk("rstmid_stall", {63'd0, O_stall}, 64'd0);
        tick;
        I_rst = 1'b0; I_valid = 1'b0; I_ren = 1'b0;
        I_dc_rvalid = 1'b1; I_dc_rdata = ~64'd0;
        sample;
        chk("late_done",  {63'd0, O_done}, 64'd0);
        chk("late_rdata", O_rdata,         64'd0);
        tick;
        I_dc_rvalid = 1'b0;
        sample;
        chk("late_done2",  {63'd0, O_done}, 64'd0);
        chk("late_rdata2", O_rdata,         64'd0);
        tick;

        // LW at a 2-byte offset.
        I_valid = 1'b1; I_ren = 1'b1; I_funct3 = 3'b010; I_addr = 32'h8000_0002;
        sample;
`ifdef YSYX_22040750_LSU_MISALIGN_CHK_EN
        chk("mis_noreq", {63'd0, O_dc_rd_req}, 64'd0);
        tick;
        sample;
        chk("mis_done",   {63'd0, O_done},      64'd1);
        chk("mis_flag",   {63'd0, O_misalign},  64'd1);
        chk("mis_rdata",  O_rdata,              64'd0);
        chk("mis_noreq2", {63'd0, O_dc_rd_req}, 64'd0);
        tick;
        I_valid = 1'b0;
        sample;
        chk("mis_done_once", {63'd0, O_done},     64'd0);
        chk("mis_flag_once", {63'd0, O_misalign}, 64'd0);
        tick;
`else
        chk("nomis_req",  {63'd0, O_dc_rd_req}, 64'd1);
        chk("nomis_flag", {63'd0, O_misalign},  64'd0);
        tick;
        I_dc_rvalid = 1'b1; I_dc_rdata = 64'h0000_DEAD_BEEF_0000;
        sample;
        tick;
        I_dc_rvalid = 1'b0;
        sample;
        chk("nomis_done",  {63'd0, O_done},     64'd1);
        chk("nomis_flag2", {63'd0, O_misalign}, 64'd0);
        chk("nomis_rdata", O_rdata,             64'hFFFF_FFFF_DEAD_BEEF);
        tick;
        I_valid = 1'b0;
        tick;
`endif

        // Both ren and wen set: handled as LBU.
        I_valid = 1'b1; I_ren = 1'b1; I_wen = 1'b1; I_funct3 = 3'b100; I_addr = 32'h8000_0013;
        sample;
        chk("both_rd", {63'd0, O_dc_rd_req}, 64'd1);
        chk("both_wr", {63'd0, O_dc_wr_req}, 64'd0);
        tick;
        I_dc_rvalid = 1'b1; I_dc_rdata = 64'h0000_0000_AB00_0000;
        sample;
        tick;
        I_dc_rvalid = 1'b0;
        sample;
        chk("both_rdata", O_rdata, 64'h0000_0000_0000_00AB);
        tick;
        I_valid = 1'b0; I_ren = 1'b0; I_wen = 1'b0;
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
